// File: rtl/reg_scoreboard.sv
`timescale 1ns / 1ps
// Register scoreboard: counts in-flight writes per architectural register,
// stalls issue on read-after-write hazards or per-register saturation.
module reg_scoreboard #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned TOT_W    = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                src1_valid,
  input  logic [IDX_W-1:0]    src1_idx,
  input  logic                src2_valid,
  input  logic [IDX_W-1:0]    src2_idx,
  input  logic                src3_valid,
  input  logic [IDX_W-1:0]    src3_idx,
  input  logic                dst_valid,
  input  logic [IDX_W-1:0]    dst_idx,
  output logic                issue_ready,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_idx,
  input  logic                flush,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic [TOT_W-1:0]    outstanding,
  output logic                err_underflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt      [NUM_REGS];
  logic [CNT_W-1:0]    cnt_next [NUM_REGS];
  logic [NUM_REGS-1:0] busy_next;
  logic [TOT_W-1:0]    tot_next;
  logic                err_next;
  logic                hazard;
  logic                sat;
  logic                issue_fire;

  // Hazard/saturation lookup; indices outside the register file never match.
  always_comb begin
    hazard = 1'b0;
    sat    = 1'b0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (cnt[i] != '0) begin
        if (src1_valid && int'(src1_idx) == i) hazard = 1'b1;
        if (src2_valid && int'(src2_idx) == i) hazard = 1'b1;
        if (src3_valid && int'(src3_idx) == i) hazard = 1'b1;
      end
      if (dst_valid && int'(dst_idx) == i && cnt[i] == CNT_MAX) sat = 1'b1;
    end
  end

  assign issue_ready = !reset && !flush && !hazard && !sat;
  assign issue_fire  = issue_valid && issue_ready;

  // Counter update; flush wins over both issue and writeback.
  always_comb begin
    err_next  = err_underflow;
    tot_next  = '0;
    busy_next = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      cnt_next[i] = cnt[i];
      if (flush) begin
        cnt_next[i] = '0;
      end else if ((issue_fire && dst_valid && int'(dst_idx) == i) &&
                   !(wb_valid && int'(wb_idx) == i)) begin
        cnt_next[i] = cnt[i] + CNT_W'(1);
      end else if (!(issue_fire && dst_valid && int'(dst_idx) == i) &&
                   (wb_valid && int'(wb_idx) == i)) begin
        if (cnt[i] != '0) cnt_next[i] = cnt[i] - CNT_W'(1);
        else              err_next    = 1'b1;
      end
      busy_next[i] = (cnt_next[i] != '0);
      tot_next     = tot_next + TOT_W'(cnt_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_REGS); i++) cnt[i] <= '0;
      busy_mask     <= '0;
      outstanding   <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_REGS); i++) cnt[i] <= cnt_next[i];
      busy_mask     <= busy_next;
      outstanding   <= tot_next;
      err_underflow <= err_next;
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
`timescale 1ns / 1ps
// Directed bench for reg_scoreboard with hand-computed expectations.
module tb_reg_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        src1_valid, src2_valid, src3_valid, dst_valid;
  logic [4:0]  src1_idx, src2_idx, src3_idx, dst_idx;
  logic        issue_ready;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic        flush;
  logic [31:0] busy_mask;
  logic [6:0]  outstanding;
  logic        err_underflow;

  int n_tests = 0;
  int n_fail  = 0;

  reg_scoreboard dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .src1_valid    (src1_valid),
    .src1_idx      (src1_idx),
    .src2_valid    (src2_valid),
    .src2_idx      (src2_idx),
    .src3_valid    (src3_valid),
    .src3_idx      (src3_idx),
    .dst_valid     (dst_valid),
    .dst_idx       (dst_idx),
    .issue_ready   (issue_ready),
    .wb_valid      (wb_valid),
    .wb_idx        (wb_idx),
    .flush         (flush),
    .busy_mask     (busy_mask),
    .outstanding   (outstanding),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    issue_valid = 1'b0; src1_valid = 1'b0; src2_valid = 1'b0; src3_valid = 1'b0;
    dst_valid = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    src1_idx = '0; src2_idx = '0; src3_idx = '0; dst_idx = '0; wb_idx = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_dst(input logic [4:0] d);
    issue_valid = 1'b1; dst_valid = 1'b1; dst_idx = d;
  endtask

  initial begin
    clr();
    reset = 1'b1;
    #3;
    check("rst_ready", 32'(issue_ready), 32'd0);
    check("rst_busy", busy_mask, 32'h0);
    check("rst_out", 32'(outstanding), 32'd0);
    check("rst_err", 32'(err_underflow), 32'd0);
    tick();
    reset = 1'b0;

    // RAW on register 3
    issue_dst(5'd3); #1;
    check("t1_ready", 32'(issue_ready), 32'd1);
    tick(); clr();
    check("t1_busy", busy_mask, 32'h0000_0008);
    check("t1_out", 32'(outstanding), 32'd1);
    issue_valid = 1'b1; src1_valid = 1'b1; src1_idx = 5'd3; #1;
    check("t1_haz_src1", 32'(issue_ready), 32'd0);
    tick();
    check("t1_haz_hold", 32'(issue_ready), 32'd0);
    src1_valid = 1'b0; src2_valid = 1'b1; src2_idx = 5'd3; #1;
    check("t1_haz_src2", 32'(issue_ready), 32'd0);
    src2_valid = 1'b0; src3_valid = 1'b1; src3_idx = 5'd3; #1;
    check("t1_haz_src3", 32'(issue_ready), 32'd0);
    wb_valid = 1'b1; wb_idx = 5'd3; #1;
    check("t1_no_bypass", 32'(issue_ready), 32'd0);
    tick(); wb_valid = 1'b0; #1;
    check("t1_ready_after_wb", 32'(issue_ready), 32'd1);
    check("t1_busy_clear", busy_mask, 32'h0);
    check("t1_out_clear", 32'(outstanding), 32'd0);
    clr(); tick();

    // WAW saturation on register 5
    issue_dst(5'd5);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t2_ready_%0d", k), 32'(issue_ready), 32'd1);
      tick();
    end
    check("t2_out3", 32'(outstanding), 32'd3);
    check("t2_busy", busy_mask, 32'h0000_0020);
    check("t2_sat", 32'(issue_ready), 32'd0);
    wb_valid = 1'b1; wb_idx = 5'd5; #1;
    check("t2_sat_same_cycle_wb", 32'(issue_ready), 32'd0);
    tick(); wb_valid = 1'b0; #1;
    check("t2_out2", 32'(outstanding), 32'd2);
    check("t2_ready_after_wb", 32'(issue_ready), 32'd1);
    tick(); clr();
    check("t2_out_back3", 32'(outstanding), 32'd3);

    // Simultaneous issue and writeback on register 7
    issue_dst(5'd7);
    tick(); clr();
    check("t3_busy_a", busy_mask, 32'h0000_00A0);
    check("t3_out_a", 32'(outstanding), 32'd4);
    issue_dst(5'd7); wb_valid = 1'b1; wb_idx = 5'd7; #1;
    check("t3_ready", 32'(issue_ready), 32'd1);
    tick(); clr();
    check("t3_busy_b", busy_mask, 32'h0000_00A0);
    check("t3_out_b", 32'(outstanding), 32'd4);

    // Underflow on idle register 9
    check("t4_err_pre", 32'(err_underflow), 32'd0);
    wb_valid = 1'b1; wb_idx = 5'd9;
    tick(); clr();
    check("t4_err_set", 32'(err_underflow), 32'd1);
    check("t4_out", 32'(outstanding), 32'd4);

    // Flush clears counters, not the sticky error
    flush = 1'b1;
    tick(); clr();
    check("t5_busy_f1", busy_mask, 32'h0);
    check("t5_out_f1", 32'(outstanding), 32'd0);
    check("t5_err_f1", 32'(err_underflow), 32'd1);
    issue_dst(5'd1); tick();
    issue_dst(5'd2); tick();
    issue_dst(5'd4); tick(); clr();
    check("t5_busy_124", busy_mask, 32'h0000_0016);
    check("t5_out_124", 32'(outstanding), 32'd3);
    flush = 1'b1; issue_dst(5'd6); wb_valid = 1'b1; wb_idx = 5'd1; #1;
    check("t5_flush_ready", 32'(issue_ready), 32'd0);
    tick(); clr();
    check("t5_busy_f2", busy_mask, 32'h0);
    check("t5_out_f2", 32'(outstanding), 32'd0);
    check("t5_err_f2", 32'(err_underflow), 32'd1);

    // Only reset clears the error; issue+wb on an idle register is no underflow
    reset = 1'b1; tick(); reset = 1'b0;
    check("t6_err_cleared", 32'(err_underflow), 32'd0);
    issue_dst(5'd10); wb_valid = 1'b1; wb_idx = 5'd10;
    tick(); clr();
    check("t6_incdec_err", 32'(err_underflow), 32'd0);
    check("t6_incdec_busy", busy_mask, 32'h0);

    // Asynchronous reset mid-cycle
    issue_dst(5'd3); tick(); tick(); clr();
    check("t7_out2", 32'(outstanding), 32'd2);
    check("t7_busy", busy_mask, 32'h0000_0008);
    #2;
    issue_dst(5'd12);
    reset = 1'b1; #1;
    check("t7_async_busy", busy_mask, 32'h0);
    check("t7_async_out", 32'(outstanding), 32'd0);
    check("t7_async_ready", 32'(issue_ready), 32'd0);
    #1;
    clr(); reset = 1'b0;
    tick();
    check("t7_post_out", 32'(outstanding), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
